// File: rtl/ball_engine_gen2.sv
// ball_engine_gen2
//   Ball-physics engine for one half of a two-board pong game. It takes a ball
//   from the opponent board, moves it across this board's field with a signed
//   Y velocity and periodic gravity, and bounces it off the top and bottom
//   walls. On a paddle collision it sends the ball back; if the paddle misses,
//   it reports a lose.
//
// Ports
//   i_clk_25MHZ, i_reset_n        clock, async active-low reset
//   i_upscale                     1: H_RES x V_RES field, 0: half-size field
//   i_pause                       freeze tick, step and collision sampling
//   i_rx_*/o_rx_ready             incoming ball handshake + payload
//   i_collision, i_paddle_speed   paddle tracker inputs
//   o_tx_*/i_tx_ready             returned ball handshake + payload
//   o_lose_valid/i_lose_ready     missed-ball handshake
//   o_ball_x, o_ball_y            ball position for the renderer
//   o_moving_out, o_idle, o_score status (all outputs registered)
module ball_engine_gen2 #(
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned COORD_W     = 10,
   parameter int unsigned VEL_W       = 8,
   parameter int unsigned BALL_SIZE   = 20,
   parameter int unsigned X_ENTRY     = 20,
   parameter int unsigned X_STEP      = 10,
   parameter int unsigned BASE_PERIOD = 270000,
   parameter int unsigned PERIOD_W    = 20,
   parameter int unsigned GRAV_PERIOD = 4,
   parameter int unsigned MAX_SHIFT   = 3,
   parameter int unsigned SCORE_W     = 8,
   localparam int unsigned GP_W = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1
) (
   input  logic                      i_clk_25MHZ,
   input  logic                      i_reset_n,
   input  logic                      i_upscale,
   input  logic                      i_pause,
   input  logic                      i_rx_valid,
   output logic                      o_rx_ready,
   input  logic [COORD_W-1:0]        i_rx_y,
   input  logic signed [VEL_W-1:0]   i_rx_vy,
   input  logic [GP_W-1:0]           i_rx_gphase,
   input  logic                      i_rx_fast,
   input  logic                      i_collision,
   input  logic [2:0]                i_paddle_speed,
   output logic                      o_tx_valid,
   input  logic                      i_tx_ready,
   output logic [COORD_W-1:0]        o_tx_y,
   output logic signed [VEL_W-1:0]   o_tx_vy,
   output logic [GP_W-1:0]           o_tx_gphase,
   output logic                      o_tx_fast,
   output logic                      o_lose_valid,
   input  logic                      i_lose_ready,
   output logic [COORD_W-1:0]        o_ball_x,
   output logic [COORD_W-1:0]        o_ball_y,
   output logic                      o_moving_out,
   output logic                      o_idle,
   output logic [SCORE_W-1:0]        o_score
);

   localparam int unsigned CW = COORD_W + 2;

   localparam logic [PERIOD_W-1:0]     BASE_P     = PERIOD_W'(BASE_PERIOD);
   localparam logic signed [VEL_W-1:0] VY_MAX     = {1'b0, {(VEL_W-1){1'b1}}};
   localparam logic signed [VEL_W-1:0] VY_MIN     = {1'b1, {(VEL_W-1){1'b0}}};
   localparam logic [COORD_W-1:0]      Y_MAX_FULL = COORD_W'(V_RES - 1);
   localparam logic [COORD_W-1:0]      Y_MAX_HALF = COORD_W'(V_RES / 2 - 1);
   localparam logic [COORD_W-1:0]      FAR_FULL   = COORD_W'(H_RES - BALL_SIZE);
   localparam logic [COORD_W-1:0]      FAR_HALF   = COORD_W'(H_RES / 2 - BALL_SIZE);
   localparam logic [COORD_W-1:0]      X_ENTRY_C  = COORD_W'(X_ENTRY);
   localparam logic [COORD_W-1:0]      X_STEP_C   = COORD_W'(X_STEP);
   localparam logic [GP_W-1:0]         GP_LAST    = GP_W'(GRAV_PERIOD - 1);
   localparam logic [SCORE_W-1:0]      SCORE_MAX  = '1;
   localparam logic [2:0]              SHIFT_CAP  = 3'(MAX_SHIFT);

   typedef enum logic [2:0] {StIdle, StRunOut, StRunBack, StSend, StLose} state_t;

   state_t                    r_state, w_state_d;
   logic [COORD_W-1:0]        r_x, w_x_d;
   logic [COORD_W-1:0]        r_y, w_y_d;
   logic signed [VEL_W-1:0]   r_vy, w_vy_d;
   logic [GP_W-1:0]           r_gphase, w_gphase_d;
   logic [PERIOD_W-1:0]       r_period, w_period_d;
   logic [PERIOD_W-1:0]       r_tick, w_tick_d;
   logic [SCORE_W-1:0]        r_score, w_score_d;
   logic                      r_rx_ready, r_idle, r_moving_out;
   logic                      r_tx_valid, r_lose_valid, r_tx_fast;

   logic [COORD_W-1:0]        w_y_max, w_far_x, w_rx_y_clamp;
   logic signed [CW-1:0]      w_y_sum, w_y_max_s;
   logic signed [VEL_W-1:0]   w_vy_grav, w_vy_neg, w_vy_step;
   logic [COORD_W-1:0]        w_y_step;
   logic [GP_W-1:0]           w_gphase_inc;
   logic [2:0]                w_shift;
   logic                      w_run, w_step;

   // Field geometry follows the live upscale input.
   assign w_y_max      = i_upscale ? Y_MAX_FULL : Y_MAX_HALF;
   assign w_far_x      = i_upscale ? FAR_FULL : FAR_HALF;
   assign w_rx_y_clamp = (i_rx_y > w_y_max) ? w_y_max : i_rx_y;
   assign w_shift      = (i_paddle_speed > SHIFT_CAP) ? SHIFT_CAP : i_paddle_speed;

   assign w_run  = (r_state == StRunOut) || (r_state == StRunBack);
   assign w_step = w_run && !i_pause && (r_tick == r_period - PERIOD_W'(1));

   // Y / velocity / gravity update applied on every step.
   always_comb begin
      w_y_sum      = $signed({2'b00, r_y}) + CW'(r_vy);
      w_y_max_s    = $signed({2'b00, w_y_max});
      w_gphase_inc = (r_gphase == GP_LAST) ? '0 : r_gphase + GP_W'(1);
      w_vy_grav    = r_vy;
      if ((r_gphase == GP_LAST) && (r_vy != VY_MAX)) begin
         w_vy_grav = r_vy + VEL_W'(1);
      end
      // Negating the most negative velocity saturates to the most positive.
      w_vy_neg  = (w_vy_grav == VY_MIN) ? VY_MAX : -w_vy_grav;
      w_y_step  = w_y_sum[COORD_W-1:0];
      w_vy_step = w_vy_grav;
      if (w_y_sum >= w_y_max_s) begin
         w_y_step  = w_y_max;
         w_vy_step = w_vy_neg;
      end else if (w_y_sum[CW-1] || (w_y_sum == '0)) begin
         w_y_step  = '0;
         w_vy_step = w_vy_neg;
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_x_d      = r_x;
      w_y_d      = r_y;
      w_vy_d     = r_vy;
      w_gphase_d = r_gphase;
      w_period_d = r_period;
      w_score_d  = r_score;
      w_tick_d   = r_tick;

      if (w_run && !i_pause) begin
         w_tick_d = w_step ? '0 : r_tick + PERIOD_W'(1);
      end

      case (r_state)
         StIdle: begin
            w_tick_d = '0;
            if (i_rx_valid && r_rx_ready) begin
               w_x_d      = X_ENTRY_C;
               w_y_d      = w_rx_y_clamp;
               w_vy_d     = i_rx_vy;
               w_gphase_d = i_rx_gphase;
               w_period_d = i_rx_fast ? (BASE_P >> 1) : BASE_P;
               w_state_d  = StRunOut;
            end
         end
         StRunOut: begin
            // Collision wins over both the far-edge check and a coincident step.
            if (!i_pause && i_collision) begin
               w_tick_d   = '0;
               w_period_d = BASE_P >> w_shift;
               w_state_d  = StRunBack;
            end else begin
               if (w_step) begin
                  w_x_d      = r_x + X_STEP_C;
                  w_y_d      = w_y_step;
                  w_vy_d     = w_vy_step;
                  w_gphase_d = w_gphase_inc;
               end
               if (r_x >= w_far_x) begin
                  w_state_d = StLose;
               end
            end
         end
         StRunBack: begin
            if (w_step) begin
               w_x_d      = (r_x > X_STEP_C) ? r_x - X_STEP_C : '0;
               w_y_d      = w_y_step;
               w_vy_d     = w_vy_step;
               w_gphase_d = w_gphase_inc;
            end
            if (r_x == '0) begin
               w_state_d = StSend;
               w_score_d = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
            end
         end
         StSend: begin
            if (r_tx_valid && i_tx_ready) begin
               w_period_d = BASE_P;
               w_state_d  = StIdle;
            end
         end
         StLose: begin
            if (r_lose_valid && i_lose_ready) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk_25MHZ or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_x          <= '0;
         r_y          <= '0;
         r_vy         <= '0;
         r_gphase     <= '0;
         r_period     <= BASE_P;
         r_tick       <= '0;
         r_score      <= '0;
         r_rx_ready   <= 1'b0;
         r_idle       <= 1'b0;
         r_moving_out <= 1'b0;
         r_tx_valid   <= 1'b0;
         r_lose_valid <= 1'b0;
         r_tx_fast    <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_x          <= w_x_d;
         r_y          <= w_y_d;
         r_vy         <= w_vy_d;
         r_gphase     <= w_gphase_d;
         r_period     <= w_period_d;
         r_tick       <= w_tick_d;
         r_score      <= w_score_d;
         // Status flags are decoded from the next state so they line up with it.
         r_rx_ready   <= (w_state_d == StIdle);
         r_idle       <= (w_state_d == StIdle);
         r_moving_out <= (w_state_d == StRunOut);
         r_tx_valid   <= (w_state_d == StSend);
         r_lose_valid <= (w_state_d == StLose);
         r_tx_fast    <= (w_period_d < BASE_P);
      end
   end

   assign o_rx_ready   = r_rx_ready;
   assign o_idle       = r_idle;
   assign o_moving_out = r_moving_out;
   assign o_tx_valid   = r_tx_valid;
   assign o_lose_valid = r_lose_valid;
   assign o_tx_fast    = r_tx_fast;
   assign o_tx_y       = r_y;
   assign o_tx_vy      = r_vy;
   assign o_tx_gphase  = r_gphase;
   assign o_ball_x     = r_x;
   assign o_ball_y     = r_y;
   assign o_score      = r_score;

endmodule

// File: tb/tb_ball_engine_gen2.sv
// tb_ball_engine_gen2
//   Bench for ball_engine_gen2 with a shortened step period. A behavioural
//   model tracks the expected ball position, velocity, gravity phase, period and
//   score, and every step is compared against the DUT.
module tb_ball_engine_gen2;

   localparam int BASE = 40;

   logic              clk;
   logic              reset_n;
   logic              upscale, pause;
   logic              rx_valid, rx_ready;
   logic [9:0]        rx_y;
   logic signed [7:0] rx_vy;
   logic [1:0]        rx_gphase;
   logic              rx_fast, collision;
   logic [2:0]        paddle_speed;
   logic              tx_valid, tx_ready;
   logic [9:0]        tx_y;
   logic signed [7:0] tx_vy;
   logic [1:0]        tx_gphase;
   logic              tx_fast, lose_valid, lose_ready;
   logic [9:0]        ball_x, ball_y;
   logic              moving_out, idle;
   logic [7:0]        score;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   int ex, ey, evy, egp, eper, phase, escore, ymax, far;
   bit eback;

   ball_engine_gen2 #(
      .BASE_PERIOD (BASE),
      .PERIOD_W    (8)
   ) dut (
      .i_clk_25MHZ    (clk),
      .i_reset_n      (reset_n),
      .i_upscale      (upscale),
      .i_pause        (pause),
      .i_rx_valid     (rx_valid),
      .o_rx_ready     (rx_ready),
      .i_rx_y         (rx_y),
      .i_rx_vy        (rx_vy),
      .i_rx_gphase    (rx_gphase),
      .i_rx_fast      (rx_fast),
      .i_collision    (collision),
      .i_paddle_speed (paddle_speed),
      .o_tx_valid     (tx_valid),
      .i_tx_ready     (tx_ready),
      .o_tx_y         (tx_y),
      .o_tx_vy        (tx_vy),
      .o_tx_gphase    (tx_gphase),
      .o_tx_fast      (tx_fast),
      .o_lose_valid   (lose_valid),
      .i_lose_ready   (lose_ready),
      .o_ball_x       (ball_x),
      .o_ball_y       (ball_y),
      .o_moving_out   (moving_out),
      .o_idle         (idle),
      .o_score        (score)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int vneg(input int v);
      return (v == -128) ? 127 : -v;
   endfunction

   task automatic set_field(input bit up);
      upscale = up;
      ymax    = up ? 479 : 239;
      far     = up ? 620 : 300;
   endtask

   // One step of ball physics, from the game rules.
   task automatic model_step();
      int ny;
      ny  = ey + evy;
      egp = (egp + 1) % 4;
      if (egp == 0 && evy < 127) evy = evy + 1;
      if (ny >= ymax) begin
         ey  = ymax;
         evy = vneg(evy);
      end else if (ny <= 0) begin
         ey  = 0;
         evy = vneg(evy);
      end else begin
         ey = ny;
      end
      if (eback) ex = (ex > 10) ? ex - 10 : 0;
      else       ex = ex + 10;
   endtask

   task automatic accept(input int y, input int vy, input int gp, input bit fast);
      rx_y      = 10'(y);
      rx_vy     = 8'(vy);
      rx_gphase = 2'(gp);
      rx_fast   = fast;
      rx_valid  = 1'b1;
      chk("rx_ready_idle", rx_ready, 1);
      tick();
      rx_valid = 1'b0;
      ex    = 20;
      ey    = (y > ymax) ? ymax : y;
      evy   = vy;
      egp   = gp;
      eper  = fast ? BASE / 2 : BASE;
      phase = 0;
      eback = 1'b0;
      chk("accept_x", ball_x, ex);
      chk("accept_y", ball_y, ey);
      chk("accept_moving_out", moving_out, 1);
      chk("accept_rx_ready", rx_ready, 0);
   endtask

   task automatic wait_step();
      repeat (eper - 1 - phase) tick();
      chk("pre_step_x", ball_x, ex);
      tick();
      phase = 0;
      model_step();
      chk("step_x", ball_x, ex);
      chk("step_y", ball_y, ey);
   endtask

   task automatic collide(input int ps, input int off);
      repeat (off) tick();
      phase        = phase + off;
      paddle_speed = 3'(ps);
      collision    = 1'b1;
      tick();
      collision = 1'b0;
      eback     = 1'b1;
      eper      = BASE >> ((ps > 3) ? 3 : ps);
      phase     = 0;
      chk("collide_back", moving_out, 0);
      chk("collide_x", ball_x, ex);
   endtask

   task automatic back_to_send();
      collision = 1'b1;  // ignored on the way back
      while (ex > 0) wait_step();
      collision = 1'b0;
      tick();
      escore = (escore < 255) ? escore + 1 : 255;
      chk("send_valid", tx_valid, 1);
   endtask

   task automatic finish_back();
      back_to_send();
      chk("send_y", tx_y, ey);
      chk("send_vy", $signed(tx_vy), evy);
      chk("send_gphase", tx_gphase, egp);
      chk("send_fast", tx_fast, (eper < BASE) ? 1 : 0);
      chk("send_score", score, escore);
      tx_ready = 1'b0;
      repeat (10) tick();
      chk("send_hold_valid", tx_valid, 1);
      chk("send_hold_y", tx_y, ey);
      chk("send_hold_vy", $signed(tx_vy), evy);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("send_done_valid", tx_valid, 0);
      chk("send_done_idle", idle, 1);
   endtask

   task automatic run_to_lose();
      while (ex < far) wait_step();
      tick();
      chk("lose_valid", lose_valid, 1);
      chk("lose_moving_out", moving_out, 0);
      rx_valid   = 1'b1;
      lose_ready = 1'b0;
      repeat (5) tick();
      chk("lose_hold", lose_valid, 1);
      chk("lose_rx_ready", rx_ready, 0);
      rx_valid   = 1'b0;
      lose_ready = 1'b1;
      tick();
      lose_ready = 1'b0;
      chk("lose_done_valid", lose_valid, 0);
      chk("lose_done_idle", idle, 1);
   endtask

   initial begin
      int n, ps, off, y, vy;
      bit up;
      reset_n      = 1'b0;
      pause        = 1'b0;
      rx_valid     = 1'b0;
      rx_y         = '0;
      rx_vy        = '0;
      rx_gphase    = '0;
      rx_fast      = 1'b0;
      collision    = 1'b0;
      paddle_speed = '0;
      tx_ready     = 1'b0;
      lose_ready   = 1'b0;
      escore       = 0;
      set_field(1'b1);

      repeat (3) tick();
      chk("rst_idle", idle, 0);
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_ball_x", ball_x, 0);
      chk("rst_score", score, 0);
      reset_n = 1'b1;
      tick();
      chk("cycle1_idle", idle, 1);
      chk("cycle1_rx_ready", rx_ready, 1);

      // Directed ball: gravity sequence, pause freeze, then a miss.
      accept(100, -3, 0, 1'b0);
      repeat (5) wait_step();
      chk("grav_y5", ball_y, 86);
      repeat (10) tick();
      phase     = 10;
      pause     = 1'b1;
      collision = 1'b1;
      repeat (1000) tick();
      chk("pause_x", ball_x, ex);
      chk("pause_y", ball_y, ey);
      chk("pause_no_collide", moving_out, 1);
      pause     = 1'b0;
      collision = 1'b0;
      wait_step();
      run_to_lose();

      // Walls on the half-size field.
      set_field(1'b0);
      accept(5, -8, 0, 1'b0);
      wait_step();
      chk("wall_top_y", ball_y, 0);
      wait_step();
      chk("wall_top_y2", ball_y, 8);
      collide(1, 5);
      finish_back();

      accept(235, 8, 3, 1'b1);
      wait_step();
      chk("wall_bot_y", ball_y, 239);
      wait_step();
      chk("wall_bot_y2", ball_y, 230);
      collide(2, 3);
      finish_back();

      accept(300, 0, 0, 1'b0);
      chk("clamp_y", ball_y, 239);
      run_to_lose();

      // Random balls returned by the paddle.
      for (int b = 0; b < 6; b++) begin
         up = 1'($urandom_range(0, 1));
         set_field(up);
         y  = int'($urandom_range(0, 500));
         vy = int'($urandom_range(0, 30)) - 15;
         accept(y, vy, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         n = int'($urandom_range(0, up ? 55 : 25));
         repeat (n) wait_step();
         ps  = int'($urandom_range(0, 7));
         off = int'($urandom_range(0, eper - 1 - phase));
         collide(ps, off);
         finish_back();
      end
      chk("score_total", score, 8);

      // Collision on the cycle of the final step, then reset during SEND.
      set_field(1'b1);
      accept(200, 1, 0, 1'b0);
      while (ex < 610) wait_step();
      collide(7, eper - 1 - phase);
      chk("edge_collide_x", ball_x, 610);
      back_to_send();
      chk("edge_send_fast", tx_fast, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_idle", idle, 0);
      chk("midrst_score", score, 0);
      chk("midrst_ball_y", ball_y, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("midrst_release_idle", idle, 1);
      chk("midrst_release_tx", tx_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
